// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
// Bundles the control inputs and the PC/EPC status outputs of pc_sequencer.
//   master : decode/control side. It drives stall, branch, jump, exc, eret,
//            halt and the two targets, and observes PCout, PCplus, epc,
//            exc_depth, halted and the two sticky flags.
//   slave  : the sequencer itself.
interface pc_sequencer_if #(
    parameter int bit_size  = 18,
    parameter int EXC_DEPTH = 4
);
    localparam int DW = $clog2(EXC_DEPTH + 1);

    logic                stall;
    logic                branch;
    logic [bit_size-1:0] branch_target;
    logic                jump;
    logic [bit_size-1:0] jump_target;
    logic                exc;
    logic                eret;
    logic                halt;
    logic [bit_size-1:0] PCout;
    logic [bit_size-1:0] PCplus;
    logic [bit_size-1:0] epc;
    logic [DW-1:0]       exc_depth;
    logic                halted;
    logic                exc_overflow;
    logic                eret_underflow;

    modport master (
        output stall, branch, branch_target, jump, jump_target, exc, eret, halt,
        input  PCout, PCplus, epc, exc_depth, halted, exc_overflow, eret_underflow
    );

    modport slave (
        input  stall, branch, branch_target, jump, jump_target, exc, eret, halt,
        output PCout, PCplus, epc, exc_depth, halted, exc_overflow, eret_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer at the head of the fetch path. It holds the PC
// and picks the next PC from the sequential, branch, jump, exception and
// return sources. It supports stall and halt/wake, and it keeps a bounded
// LIFO of exception return addresses so that exceptions can nest.
//   clk, rst : clock; asynchronous active-high reset
//   bus      : pc_sequencer_if.slave. Control inputs, PCout/PCplus, the EPC
//              stack top and depth, halted, and the sticky overflow and
//              underflow flags.
//
// state  | meaning
// RUN    | normal fetch; the prioritised next-PC select is active
// HALTED | PC and stack frozen; only exc wakes the sequencer
module pc_sequencer #(
    parameter int          bit_size     = 18,
    parameter int unsigned STEP         = 4,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned EXC_VECTOR   = 'h100,
    parameter int          EXC_DEPTH    = 4
) (
    input logic            clk,
    input logic            rst,
    pc_sequencer_if.slave  bus
);
    localparam int DW = $clog2(EXC_DEPTH + 1);
    localparam int IW = (EXC_DEPTH > 1) ? $clog2(EXC_DEPTH) : 1;

    typedef enum logic {RUN, HALTED} state_t;

    state_t              state, state_next;
    logic [bit_size-1:0] pc, pc_next, pc_plus, top;
    logic [DW-1:0]       depth, depth_next;
    logic [bit_size-1:0] stack [EXC_DEPTH];
    logic [IW-1:0]       top_idx, push_idx;
    logic                push, ovf_set, unf_set, ovf, unf;
    logic                stack_full, stack_empty;

    assign pc_plus     = pc + bit_size'(STEP);
    assign stack_full  = (depth == DW'(EXC_DEPTH));
    assign stack_empty = (depth == '0);
    assign top_idx     = IW'(depth - 1'b1);
    assign push_idx    = IW'(depth);
    // Stale stack entries are never reset, so an empty stack must read as zero.
    assign top         = stack_empty ? '0 : stack[top_idx];

    always_comb begin
        state_next = state;
        pc_next    = pc;
        depth_next = depth;
        push       = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        // exc wins in both states; in HALTED it is also the only wake source.
        if (bus.exc) begin
            pc_next    = bit_size'(EXC_VECTOR);
            state_next = RUN;
            if (stack_full) begin
                ovf_set = 1'b1;
            end else begin
                push       = 1'b1;
                depth_next = depth + 1'b1;
            end
        end else if (state == RUN && !bus.stall) begin
            if (bus.eret) begin
                if (stack_empty) begin
                    pc_next = pc_plus;
                    unf_set = 1'b1;
                end else begin
                    pc_next    = top;
                    depth_next = depth - 1'b1;
                end
            end else if (bus.jump) begin
                pc_next = bus.jump_target;
            end else if (bus.branch) begin
                pc_next = bus.branch_target;
            end else if (bus.halt) begin
                pc_next    = pc_plus;
                state_next = HALTED;
            end else begin
                pc_next = pc_plus;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= bit_size'(RESET_VECTOR);
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            depth <= depth_next;
            ovf   <= ovf | ovf_set;
            unf   <= unf | unf_set;
        end
    end

    // Entry storage carries no reset; validity is tracked by depth alone.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[push_idx] <= pc;
        end
    end

    assign bus.PCout          = pc;
    assign bus.PCplus         = pc_plus;
    assign bus.epc            = top;
    assign bus.exc_depth      = depth;
    assign bus.halted         = (state == HALTED);
    assign bus.exc_overflow   = ovf;
    assign bus.eret_underflow = unf;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    localparam int BS    = 18;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.bit_size(BS), .EXC_DEPTH(DEPTH)) bus ();

    pc_sequencer #(
        .bit_size(BS), .STEP(4), .RESET_VECTOR(0), .EXC_VECTOR('h100), .EXC_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: PC value, EPC stack as a queue, halt flag, sticky flags.
    logic [BS-1:0] m_pc = '0;
    logic [BS-1:0] m_stack[$];
    bit            m_halted = 1'b0;
    bit            m_ovf    = 1'b0;
    bit            m_unf    = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = '0;
            m_stack.delete();
            m_halted = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (bus.exc) begin
            if (m_stack.size() == DEPTH) m_ovf = 1'b1;
            else m_stack.push_back(m_pc);
            m_pc = 'h100;
            m_halted = 1'b0;
        end else if (!m_halted && !bus.stall) begin
            if (bus.eret) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin
                    m_pc = m_pc + 4;
                    m_unf = 1'b1;
                end
            end else if (bus.jump) m_pc = bus.jump_target;
            else if (bus.branch) m_pc = bus.branch_target;
            else begin
                m_pc = m_pc + 4;
                if (bus.halt) m_halted = 1'b1;
            end
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        logic [BS-1:0] m_plus, m_epc;
        if (cmp_en) begin
            m_plus = m_pc + 4;
            m_epc  = (m_stack.size() > 0) ? m_stack[m_stack.size()-1] : '0;
            chk("cyc_pcout",  bus.PCout, m_pc);
            chk("cyc_pcplus", bus.PCplus, m_plus);
            chk("cyc_epc",    bus.epc, m_epc);
            chk("cyc_depth",  bus.exc_depth, m_stack.size());
            chk("cyc_halted", bus.halted, m_halted);
            chk("cyc_ovf",    bus.exc_overflow, m_ovf);
            chk("cyc_unf",    bus.eret_underflow, m_unf);
        end
    end

    // One clock edge with the given controls; returns at posedge+1.
    task automatic step(input logic x, input logic s, input logic e, input logic j,
                        input logic b, input logic h,
                        input logic [BS-1:0] jt, input logic [BS-1:0] bt);
        @(negedge clk);
        bus.exc = x; bus.stall = s; bus.eret = e; bus.jump = j;
        bus.branch = b; bus.halt = h; bus.jump_target = jt; bus.branch_target = bt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic jump_to(input logic [BS-1:0] t);
        step(0, 0, 0, 1, 0, 0, t, '0);
    endtask

    // Mid-cycle asynchronous reset, then one idle edge.
    task automatic reset_async();
        @(negedge clk);
        bus.exc = 0; bus.stall = 0; bus.eret = 0; bus.jump = 0; bus.branch = 0; bus.halt = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_pcout", bus.PCout, 0);
        chk("arst_depth", bus.exc_depth, 0);
        chk("arst_epc", bus.epc, 0);
        chk("arst_halted", bus.halted, 0);
        chk("arst_ovf", bus.exc_overflow, 0);
        chk("arst_unf", bus.eret_underflow, 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.exc = 0; bus.stall = 0; bus.eret = 0; bus.jump = 0; bus.branch = 0; bus.halt = 0;
        bus.jump_target = '0; bus.branch_target = '0;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_pcout", bus.PCout, 0);
        chk("reset_pcplus", bus.PCplus, 4);
        chk("reset_depth", bus.exc_depth, 0);
        idle(); chk("seq_4", bus.PCout, 'h4);
        idle(); chk("seq_8", bus.PCout, 'h8);
        idle(); chk("seq_12", bus.PCout, 'hC);

        reset_async();
        jump_to('h20);                          chk("pri_setup", bus.PCout, 'h20);
        step(0, 0, 0, 1, 1, 0, 'h80, 'h40);     chk("pri_jump_over_branch", bus.PCout, 'h80);
        step(0, 1, 0, 1, 0, 0, 'h90, '0);       chk("pri_stall_over_jump", bus.PCout, 'h80);
        step(1, 1, 0, 0, 0, 0, '0, '0);
        chk("pri_exc_pc", bus.PCout, 'h100);
        chk("pri_exc_epc", bus.epc, 'h80);
        chk("pri_exc_depth", bus.exc_depth, 1);

        reset_async();
        jump_to('h10);
        step(1, 0, 0, 0, 0, 0, '0, '0);          chk("nest_first_epc", bus.epc, 'h10);
        idle();                                  chk("nest_advance", bus.PCout, 'h104);
        step(1, 0, 0, 0, 0, 0, '0, '0);
        chk("nest_depth2", bus.exc_depth, 2);
        chk("nest_epc2", bus.epc, 'h104);
        step(0, 0, 1, 0, 0, 0, '0, '0);
        chk("ret1_pc", bus.PCout, 'h104);
        chk("ret1_depth", bus.exc_depth, 1);
        step(0, 0, 1, 0, 0, 0, '0, '0);
        chk("ret2_pc", bus.PCout, 'h10);
        chk("ret2_depth", bus.exc_depth, 0);
        chk("ret2_epc", bus.epc, 0);

        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, '0, '0);
        chk("ovf_full_no_flag", bus.exc_overflow, 0);
        step(1, 0, 0, 0, 0, 0, '0, '0);
        chk("ovf_depth", bus.exc_depth, 4);
        chk("ovf_flag", bus.exc_overflow, 1);
        chk("ovf_pc", bus.PCout, 'h100);

        reset_async();
        jump_to('h30);
        step(0, 0, 1, 0, 0, 0, '0, '0);
        chk("unf_pc", bus.PCout, 'h34);
        chk("unf_flag", bus.eret_underflow, 1);

        reset_async();
        jump_to('h50);
        step(0, 0, 0, 0, 0, 1, '0, '0);
        chk("halt_pc", bus.PCout, 'h54);
        chk("halt_flag", bus.halted, 1);
        jump_to('h200);                          chk("halt_ign_jump", bus.PCout, 'h54);
        step(0, 0, 1, 0, 0, 0, '0, '0);
        chk("halt_ign_eret", bus.PCout, 'h54);
        chk("halt_ign_eret_unf", bus.eret_underflow, 0);
        step(1, 0, 0, 0, 0, 0, '0, '0);
        chk("wake_pc", bus.PCout, 'h100);
        chk("wake_epc", bus.epc, 'h54);
        chk("wake_halted", bus.halted, 0);
        step(0, 0, 1, 0, 0, 0, '0, '0);          chk("wake_ret", bus.PCout, 'h54);

        jump_to('h3FFFC);                        chk("wrap_plus_pre", bus.PCplus, 0);
        idle();
        chk("wrap_pc", bus.PCout, 0);
        chk("wrap_plus", bus.PCplus, 4);

        reset_async();
        for (int i = 0; i < 120; i++) begin
            step($urandom_range(7) == 0, $urandom_range(5) == 0, $urandom_range(4) == 0,
                 $urandom_range(5) == 0, $urandom_range(5) == 0, $urandom_range(9) == 0,
                 BS'($urandom), BS'($urandom));
        end
        idle();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle MIPS datapath, the next generation of the plain PC register. It holds the PC and selects the next PC from sequential, branch, jump, exception and return sources. It handles stall and halt/wake, and keeps a bounded stack of exception return addresses (EPC) so exceptions can nest. It sits at the head of the fetch path: `PCout` drives instruction memory, and `PCplus` feeds link/branch adders.

## Interface
Parameters:
- bit_size, 18, width of every address
- STEP, 4, sequential increment
- RESET_VECTOR, 0, PC value loaded by reset
- EXC_VECTOR, 'h100, PC value loaded on exception
- EXC_DEPTH, 4, EPC stack entries (≥1)

Ports (DW = $clog2(EXC_DEPTH+1)):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC this cycle
- branch  in  1  take branch_target
- branch_target  in  bit_size  branch destination
- jump  in  1  take jump_target
- jump_target  in  bit_size  jump / jr destination
- exc  in  1  exception or interrupt request, sampled each cycle
- eret  in  1  return from exception
- halt  in  1  halt instruction at PCout
- PCout  out  bit_size  current PC (registered)
- PCplus  out  bit_size  PCout + STEP, combinational, modulo 2^bit_size
- epc  out  bit_size  top EPC stack entry; 0 when stack empty
- exc_depth  out  DW  number of valid EPC entries
- halted  out  1  state == HALTED
- exc_overflow  out  1  sticky: exception taken while stack full
- eret_underflow  out  1  sticky: eret taken while stack empty

## Operation

**Reset (rst = 1, asynchronous).** PCout = RESET_VECTOR, state = RUN, stack emptied, exc_depth = 0, epc = 0, halted = 0, both sticky flags 0. Stack entry contents are don't-care but must never be visible on `epc`.

**State RUN.** The highest-priority true condition below wins; exactly one action is taken per cycle.

1. **exc.** PCout ← EXC_VECTOR; push the current PCout.
   - If exc_depth == EXC_DEPTH: no push, stack unchanged, exc_overflow ← 1.
2. **stall.** PCout, stack and state all hold.
3. **eret.** If exc_depth > 0: PCout ← epc; pop.
   - If exc_depth == 0: PCout ← PCplus, eret_underflow ← 1.
4. **jump.** PCout ← jump_target.
5. **branch.** PCout ← branch_target.
6. **halt.** PCout ← PCplus; state ← HALTED.
7. **Otherwise.** PCout ← PCplus.

**State HALTED.**
- PCout and stack hold; stall, branch, jump, eret and halt are ignored.
- exc: push PCout (the address after the halt instruction), PCout ← EXC_VECTOR, state ← RUN. The same overflow rule as RUN applies.

**Stack rules.**
- LIFO. `epc` always shows the most recent un-popped entry.
- Push and pop never happen in the same cycle, because of the priority order.
- Sticky flags clear only on rst.

**Width and arithmetic.**
- All PC arithmetic is modulo 2^bit_size: PCout = 2^bit_size − STEP wraps to 0 on sequential advance.
- Targets are used unmodified; there is no alignment check.

## Timing
- Single-cycle decision: inputs sampled at a rising edge take effect on PCout at that same edge. Latency is 1 clock from input to PCout.
- PCplus follows PCout combinationally within the same cycle.
- epc, exc_depth, halted and the flags are registered and change only at a rising edge or on rst.
- rst asserted mid-cycle forces every output to its reset value immediately, whatever the state or stack contents. Release is synchronous to the next rising edge, with no other state required.
- exc held high for N cycles in RUN is N exceptions. Each pushes the then-current PCout, which is EXC_VECTOR after the first.

## Test plan
- **Reset/sequential.** RESET_VECTOR = 0, no control for 3 cycles → PCout 0, 4, 8, 12. Pulse rst asynchronously mid-cycle → PCout 0 before the next edge.
- **Priority.** At PCout = 'h20, assert jump ('h80) + branch ('h40) → 'h80. Next cycle assert stall + jump → PCout stays 'h80. Next cycle assert exc + stall → 'h100, epc 'h80, exc_depth 1.
- **Nesting/return.** Exceptions at PCout 'h10, then 'h104 → exc_depth 2, epc 'h104. eret → PCout 'h104, exc_depth 1. eret → PCout 'h10, exc_depth 0, epc 0.
- **Overflow/underflow.** EXC_DEPTH = 4, hold exc for 5 cycles → exc_depth 4, exc_overflow 1, PCout 'h100. With an empty stack, eret at 'h30 → PCout 'h34, eret_underflow 1.
- **Halt/wake.** halt at PCout 'h50 → next PCout 'h54, halted 1. Jump/eret during HALTED → no change. exc → PCout 'h100, epc 'h54, halted 0. eret → 'h54.
- **Wrap.** bit_size = 18, PCout = 'h3FFFC, advance → PCout 0, PCplus 4.
